pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit; successor to the fixed 4-bit ripple adder.
- Splits a WIDTH-bit operation into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages.
- Accepts one operation per cycle under a valid/ready handshake with full backpressure.
- Used as the arithmetic datapath feeding accumulator and ALU blocks.

Parameters:
- WIDTH, 16: operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits added per pipeline stage.
- STAGES, WIDTH/CHUNK: derived, not overridden; equals pipeline depth and latency.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, c, sub are valid this cycle
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = a+b+c; 1 = a-b-c
- out_valid  output  1  sum/carry valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result modulo 2^WIDTH
- carry  output  1  carry-out (add); NOT-borrow (sub)

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, sum, carry and all pipeline registers clear to 0; out_valid=0. in_ready=1 once reset is released.
- Operand conditioning at accept: b_eff = sub ? ~b : b; cin_eff = c ^ sub. This gives a+~b+~c = a-b-c for sub=1.
- Stage k (0..STAGES-1) adds slice [k*CHUNK +: CHUNK] of a and b_eff plus the carry registered by stage k-1 (stage 0 uses cin_eff).
- Higher slices of a and b_eff are delayed alongside; lower result slices are carried forward, so all bits of one operation emerge together.
- Global advance: adv = !out_valid || out_ready. in_ready = adv.
  - When adv=1, every stage shifts by one, including bubble valid bits.
  - When adv=0, every register holds.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Latency: exactly STAGES cycles from accept to out_valid when no stall occurs. Throughput: 1 op/cycle.
- in_valid=0 on an advancing cycle inserts a bubble (valid bit 0); bubbles never raise out_valid.
- sum/carry hold stable while out_valid=1 && out_ready=0.
- Simultaneous output transfer and new input in the same cycle is legal; there are no lost or duplicated results.
- Carry ripples across all stage boundaries: 0xFFFF+0x0001 must produce carry=1 at the last stage.
- Asserting rst_n low mid-operation discards every in-flight result. There is no partial output after reset release.
- STAGES=1 (CHUNK=WIDTH) degenerates to a registered single-cycle adder with the same handshake.
- Elaboration fails (generate-time error) if WIDTH % CHUNK != 0.

Optional Feature:
- Macro ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), aligned with sum.
  - ovf = signed two's-complement overflow = carry into MSB XOR carry out of MSB, using b_eff.
  - ovf resets to 0 and holds with sum under stall.
- Undefined: no ovf port and no related logic; all other behaviour is identical.

Test Plan (WIDTH=16, CHUNK=4, latency 4):
- Add, no stall: a=0x0003, b=0x0005, c=0, sub=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0x0008, carry=0.
- Full carry ripple: a=0xFFFF, b=0x0001, c=0 -> sum=0x0000, carry=1. Separately a=0x7FFF, b=0x8000, c=1 -> sum=0x0000, carry=1.
- Subtract: a=0x0010, b=0x0001, c=0, sub=1 -> sum=0x000F, carry=1. Then a=0x0000, b=0x0001, sub=1 -> sum=0xFFFF, carry=0 (borrow).
- Backpressure:
  - Stimulus: stream 6 back-to-back ops (a=i, b=i, i=1..6); hold out_ready=0 from cycle 5 to cycle 9.
  - Required: in_ready=0 while out_valid && !out_ready; sums appear in order 2,4,6,8,10,12 with no loss or duplication; sum held stable during the stall.
- Reset mid-flight: issue 3 ops, pull rst_n low for 1 cycle before any result -> out_valid=0 immediately (asynchronous), and no result emerges for the following 6 cycles.
- ADDER_OVF_EN defined: a=0x7FFF, b=0x0001, sub=0 -> ovf=1, sum=0x8000. a=0x8000, b=0x0001, sub=1 -> ovf=1, sum=0x7FFF. a=0x0003, b=0x0005 -> ovf=0.

Source files
------------

// File: rtl/pipelined_adder.sv
// pipelined_adder
// ---------------------------------------------------------------------------
// Pipelined add/subtract unit. A WIDTH-bit operation is split into CHUNK-bit
// slices and each pipeline stage adds one slice, registering its carry for
// the next stage. Latency is STAGES = WIDTH/CHUNK cycles and one operation
// can be accepted every cycle.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake for operands a, b, c, sub
//   a, b [WIDTH]          operands
//   c                     carry-in (add) or borrow-in (sub)
//   sub                   0: a+b+c   1: a-b-c
//   out_valid / out_ready output handshake for sum, carry
//   sum [WIDTH]           result modulo 2^WIDTH
//   carry                 carry-out (add) or NOT-borrow (sub)
//   ovf                   signed overflow, present only with ADDER_OVF_EN
//
// Build option: define ADDER_OVF_EN to add the ovf output.
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// whole pipeline advances together when the output register is empty or
// being drained (adv = !out_valid || out_ready); otherwise every register
// holds, so in_ready = adv and sum/carry stay stable during a stall.
// ---------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = WIDTH / CHUNK;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
    end

    // Stage k registers hold the state after slice k has been added: the
    // operands (upper slices still needed downstream), the partial result,
    // the carry out of slice k and the stage valid bit.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];

    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_d [STAGES];
    logic             v_d [STAGES];

    // Inputs seen by each stage: stage 0 sees the conditioned operands,
    // stage k sees the registers of stage k-1.
    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] s_src [STAGES];
    logic             c_src [STAGES];
    logic             v_src [STAGES];
    logic [CHUNK:0]   slice [STAGES];

    logic adv;

    always_comb begin
        adv = !v_q[STAGES-1] || out_ready;

        // Subtraction as a + ~b + ~c, i.e. a - b - c in two's complement.
        a_src[0] = a;
        b_src[0] = sub ? ~b : b;
        s_src[0] = '0;
        c_src[0] = c ^ sub;
        v_src[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
            c_src[k] = c_q[k-1];
            v_src[k] = v_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            slice[k] = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                     + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, c_src[k]};
            a_d[k] = a_src[k];
            b_d[k] = b_src[k];
            s_d[k] = s_src[k];
            s_d[k][k*CHUNK +: CHUNK] = slice[k][CHUNK-1:0];
            c_d[k] = slice[k][CHUNK];
            v_d[k] = v_src[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
        end else if (adv) begin
            // Bubbles shift through too, so a stage with v=0 simply
            // carries don't-care data that never reaches out_valid.
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
                v_q[k] <= v_d[k];
            end
        end
    end

`ifdef ADDER_OVF_EN
    // Overflow = carry into MSB xor carry out of MSB. The carry into the MSB
    // is recovered from the MSB sum bit: cin_msb = a_msb ^ b_msb ^ s_msb.
    logic ovf_d;
    logic ovf_q;

    always_comb begin
        ovf_d = a_src[STAGES-1][WIDTH-1] ^ b_src[STAGES-1][WIDTH-1]
              ^ s_d[STAGES-1][WIDTH-1] ^ c_d[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = adv;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign carry     = c_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder
// Randomised and directed bench for pipelined_adder (WIDTH=16, CHUNK=4).
// Expected results come from an arithmetic model of a+b+c / a-b-c.
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int LAT = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry;
`ifdef ADDER_OVF_EN
  logic         ovf;
`endif

  pipelined_adder #(.WIDTH(W), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .carry     (carry)
  );

  int n_cmp;
  int n_err;

  // Scoreboard entries: {ovf, carry, sum}
  logic [W+1:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
    longint ux, uy, sx, sy, u, sr, cl;
    logic cy, ov;
    logic [W-1:0] r;
    ux = longint'(x);
    uy = longint'(y);
    cl = ci ? 1 : 0;
    sx = ux - (x[W-1] ? 65536 : 0);
    sy = uy - (y[W-1] ? 65536 : 0);
    if (!s) begin
      u  = ux + uy + cl;
      cy = (u > 65535);
      sr = sx + sy + cl;
    end else begin
      u  = ux - uy - cl;
      cy = (ux >= uy + cl);
      sr = sx - sy - cl;
    end
    r  = u[W-1:0];
    ov = (sr > 32767) || (sr < -32768);
    return {ov, cy, r};
  endfunction

  function automatic logic [W+1:0] observed();
`ifdef ADDER_OVF_EN
    return {ovf, carry, sum};
`else
    return {1'b0, carry, sum};
`endif
  endfunction

  // Compare mask: ovf bit only exists with ADDER_OVF_EN.
  function automatic logic [W+1:0] cmp_mask();
`ifdef ADDER_OVF_EN
    return {(W+2){1'b1}};
`else
    return {1'b0, {(W+1){1'b1}}};
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    c        = 1'b0;
    sub      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({out_valid, carry, sum} !== {1'b0, 1'b0, 16'h0000}) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%0b c=%0b s=%h want v=0 c=0 s=0000",
               out_valid, carry, sum);
    end
`ifdef ADDER_OVF_EN
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ovf: got %0b want 0", ovf);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         sub;
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[8];
    tbl[0] = '{16'h0003, 16'h0005, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h8000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[3] = '{16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0};
    tbl[4] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tbl[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[7] = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = tbl[i].a; b = tbl[i].b; c = tbl[i].c; sub = tbl[i].sub;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL dir%0d_in_ready: got %0b want 1", i, in_ready);
      end
      for (int k = 1; k <= LAT; k++) begin
        @(negedge clk);
        drive_idle();
        #1;
        n_cmp++;
        if (out_valid !== (k == LAT)) begin
          n_err++;
          $display("FAIL dir%0d_latency: cycle %0d out_valid got %0b want %0b",
                   i, k, out_valid, (k == LAT));
        end
      end
      n_cmp++;
      if ({carry, sum} !== {tbl[i].carry, tbl[i].sum}) begin
        n_err++;
        $display("FAIL dir%0d_result: got c=%0b s=%h want c=%0b s=%h",
                 i, carry, sum, tbl[i].carry, tbl[i].sum);
      end
`ifdef ADDER_OVF_EN
      n_cmp++;
      if (ovf !== tbl[i].ovf) begin
        n_err++;
        $display("FAIL dir%0d_ovf: got %0b want %0b", i, ovf, tbl[i].ovf);
      end
`endif
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int sent, got, stall_cycles;
    logic [W-1:0] held;
    logic held_v;
    sent = 0; got = 0; stall_cycles = 0; held_v = 1'b0; held = '0;
    for (int t = 0; t < 40 && got < 6; t++) begin
      @(negedge clk);
      in_valid  = (sent < 6);
      a         = 16'(sent + 1);
      b         = 16'(sent + 1);
      c         = 1'b0;
      sub       = 1'b0;
      out_ready = !(t >= 5 && t <= 9);
      #1;
      n_cmp++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_err++;
        $display("FAIL bp_in_ready: t=%0d got %0b want %0b", t, in_ready,
                 (!out_valid || out_ready));
      end
      if (out_valid && !out_ready) stall_cycles++;
      if (held_v) begin
        n_cmp++;
        if (!out_valid || sum !== held) begin
          n_err++;
          $display("FAIL bp_hold: t=%0d got v=%0b s=%h want v=1 s=%h", t,
                   out_valid, sum, held);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if ({carry, sum} !== {1'b0, 16'(2 * (got + 1))}) begin
          n_err++;
          $display("FAIL bp_order: got c=%0b s=%h want c=0 s=%h", carry, sum,
                   16'(2 * (got + 1)));
        end
        got++;
      end
      held_v = out_valid && !out_ready;
      held   = sum;
      if (in_valid && in_ready) sent++;
    end
    drive_idle();
    out_ready = 1'b1;
    n_cmp++;
    if (got !== 6) begin
      n_err++;
      $display("FAIL bp_count: got %0d results want 6", got);
    end
    n_cmp++;
    if (stall_cycles !== 5) begin
      n_err++;
      $display("FAIL bp_stall_len: got %0d stalled cycles want 5", stall_cycles);
    end
    repeat (LAT + 1) @(negedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_no_dup: got out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [W+1:0] exp_v, held;
    logic held_v;
    int got;
    logic [W-1:0] edge_vals[4];
    edge_vals[0] = 16'h0000; edge_vals[1] = 16'hFFFF;
    edge_vals[2] = 16'h7FFF; edge_vals[3] = 16'h8000;
    exp_q.delete();
    held_v = 1'b0; held = '0; got = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      in_valid  = (t < 370) && ($urandom_range(0, 9) < 7);
      a         = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)]
                                              : 16'($urandom);
      b         = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)]
                                              : 16'($urandom);
      c         = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = (t >= 370) || ($urandom_range(0, 9) < 7);
      #1;
      n_cmp++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_err++;
        $display("FAIL rnd_in_ready: t=%0d got %0b want %0b", t, in_ready,
                 (!out_valid || out_ready));
      end
      if (held_v) begin
        n_cmp++;
        if (!out_valid || ((observed() & cmp_mask()) !== (held & cmp_mask()))) begin
          n_err++;
          $display("FAIL rnd_hold: t=%0d got v=%0b %h want v=1 %h", t, out_valid,
                   observed(), held);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rnd_extra: t=%0d unexpected result %h", t, observed());
        end else begin
          exp_v = exp_q.pop_front();
          if ((observed() & cmp_mask()) !== (exp_v & cmp_mask())) begin
            n_err++;
            $display("FAIL rnd_result: t=%0d got %h want %h", t,
                     observed() & cmp_mask(), exp_v & cmp_mask());
          end
        end
        got++;
      end
      held_v = out_valid && !out_ready;
      held   = observed();
      if (in_valid && in_ready) exp_q.push_back(model(a, b, c, sub));
    end
    drive_idle();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL rnd_drain: %0d results missing want 0", exp_q.size());
    end
    n_cmp++;
    if (got < 100) begin
      n_err++;
      $display("FAIL rnd_volume: got %0d results want >=100", got);
    end
  endtask

  task automatic test_reset_midflight();
    bit seen;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 16'(i + 10); b = 16'(i + 20); c = 1'b0; sub = 1'b0;
    end
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_valid: got %0b want 0", out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL mid_no_result: got out_valid=1 after reset want 0");
    end

    // Stalled result must vanish at once when reset falls with clk low.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'h1234; b = 16'h0102; c = 1'b1; sub = 1'b0;
    @(negedge clk);
    drive_idle();
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      #1;
      seen = out_valid;
    end
    n_cmp++;
    if (!seen || sum !== 16'h1337) begin
      n_err++;
      $display("FAIL async_pre: got v=%0b s=%h want v=1 s=1337", seen, sum);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, carry, sum} !== {1'b0, 1'b0, 16'h0000}) begin
      n_err++;
      $display("FAIL async_clear: got v=%0b c=%0b s=%h want v=0 c=0 s=0000",
               out_valid, carry, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL async_no_result: got out_valid=1 want 0");
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_backpressure();
    do_reset();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    if (n_err == 0) $display("*** TEST PASSED ***");
    else            $display("*** TEST FAILED ***");
    $finish;
  end

endmodule
